// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state encoding, default sizing and timer-width helper for the RO PUF controller
package ro_puf_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, COMPARE} state_t;
  localparam int N_RO_DEF       = 16;
  localparam int SETTLE_CYC_DEF = 8;
  localparam int WIN_CYC_DEF    = 1024;
  localparam int CNT_W_DEF      = 16;
  function automatic int tmr_width(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction
endpackage

// File: rtl/ro_puf_ctrl_edge_counter.sv
// ro_edge_counter: synchronizes one raw oscillator, detects rising edges and counts them with saturation
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  logic [1:0]       sync_q, sync_d;
  logic             hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[0], raw};
    hist_d = sync_q[1];
    cnt_d  = clr ? '0 : (cnt_en && sync_q[1] && !hist_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end
  assign cnt = cnt_q;
  assign sat = &cnt_q;
endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: challenge/response sequencer that enables two ring oscillators, counts their edges over a window and compares
module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int N_RO       = N_RO_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int WIN_CYC    = WIN_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  localparam int SEL_W     = $clog2(N_RO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] chal_a,
  input  logic [SEL_W-1:0] chal_b,
  output logic             busy,
  output logic [N_RO-1:0]  ro_en,
  input  logic [N_RO-1:0]  ro_out,
  output logic             resp,
  output logic             resp_valid,
  output logic             tie,
  output logic             sat,
  output logic             err,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);
  localparam int TMR_W = tmr_width(WIN_CYC > SETTLE_CYC ? WIN_CYC : SETTLE_CYC);
  localparam logic [SEL_W:0]   N_LIM       = (SEL_W+1)'(N_RO);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SEL_W-1:0] ca_q, ca_d, cb_q, cb_d;
  logic             busy_q, busy_d, resp_q, resp_d, resp_valid_q, resp_valid_d;
  logic             tie_q, tie_d, sat_q, sat_d, err_q, err_d;
  logic [N_RO-1:0]  ro_en_q, ro_en_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0] ctr_a, ctr_b;
  logic             ctr_sat_a, ctr_sat_b, accept, legal, cmp;

  assign accept = (state_q == IDLE) && start;
  assign legal  = (chal_a != chal_b) && ({1'b0, chal_a} < N_LIM) && ({1'b0, chal_b} < N_LIM);
  assign cmp    = (state_q == COMPARE);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst(rst), .raw(ro_out[ca_q]), .clr(state_q == SETTLE),
    .cnt_en(state_q == MEASURE), .cnt(ctr_a), .sat(ctr_sat_a)
  );
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst(rst), .raw(ro_out[cb_q]), .clr(state_q == SETTLE),
    .cnt_en(state_q == MEASURE), .cnt(ctr_b), .sat(ctr_sat_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      ca_q         <= '0;
      cb_q         <= '0;
      busy_q       <= 1'b0;
      ro_en_q      <= '0;
      resp_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      tie_q        <= 1'b0;
      sat_q        <= 1'b0;
      err_q        <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      ca_q         <= ca_d;
      cb_q         <= cb_d;
      busy_q       <= busy_d;
      ro_en_q      <= ro_en_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      tie_q        <= tie_d;
      sat_q        <= sat_d;
      err_q        <= err_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        state_d = (accept && legal) ? SETTLE : IDLE;
        tmr_d   = '0;
      end
      SETTLE: begin
        state_d = (tmr_q == SETTLE_LAST) ? MEASURE : SETTLE;
        tmr_d   = (tmr_q == SETTLE_LAST) ? '0 : tmr_q + 1'b1;
      end
      MEASURE: begin
        state_d = (tmr_q == WIN_LAST) ? COMPARE : MEASURE;
        tmr_d   = (tmr_q == WIN_LAST) ? '0 : tmr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The challenge is captured on every accepted start so err and the enables agree on the same indices
  always_comb begin
    ca_d         = accept ? chal_a : ca_q;
    cb_d         = accept ? chal_b : cb_q;
    busy_d       = (state_d != IDLE);
    ro_en_d      = (state_d == SETTLE || state_d == MEASURE) ? ((N_RO'(1) << ca_d) | (N_RO'(1) << cb_d)) : '0;
    err_d        = accept && !legal;
    resp_valid_d = cmp;
    resp_d       = cmp ? (ctr_a > ctr_b) : resp_q;
    tie_d        = cmp ? (ctr_a == ctr_b) : tie_q;
    sat_d        = cmp ? (ctr_sat_a || ctr_sat_b) : sat_q;
    cnt_a_d      = cmp ? ctr_a : cnt_a_q;
    cnt_b_d      = cmp ? ctr_b : cnt_b_q;
  end

  assign busy       = busy_q;
  assign ro_en      = ro_en_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;
  assign tie        = tie_q;
  assign sat        = sat_q;
  assign err        = err_q;
  assign cnt_a      = cnt_a_q;
  assign cnt_b      = cnt_b_q;
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl: self-checking bench with oscillator stubs, a directed vector table, corner sequences and random challenges
module tb_ro_puf_ctrl;
  localparam int N = 16;
  localparam int LAT = 8 + 1024 + 2;
  localparam int WIN_NS = 1024 * 10;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0]  chal_a = '0, chal_b = '0;
  logic        busy, resp, resp_valid, tie, sat, err;
  logic [15:0] ro_en, cnt_a, cnt_b, ro_out;
  logic        s_busy, s_resp, s_rv, s_tie, s_sat, s_err;
  logic [15:0] s_en;
  logic [3:0]  s_cnt_a, s_cnt_b;
  int          half_ns [N];
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    int a;
    int b;
    bit exp_err;
    bit exp_resp;
    bit exp_tie;
  } vec_t;
  vec_t tbl [4];

  ro_puf_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .chal_a(chal_a), .chal_b(chal_b),
    .busy(busy), .ro_en(ro_en), .ro_out(ro_out), .resp(resp), .resp_valid(resp_valid),
    .tie(tie), .sat(sat), .err(err), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  ro_puf_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .chal_a(chal_a), .chal_b(chal_b),
    .busy(s_busy), .ro_en(s_en), .ro_out(ro_out), .resp(s_resp), .resp_valid(s_rv),
    .tie(s_tie), .sat(s_sat), .err(s_err), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
  );

  always #5ns clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : osc
    logic r = 1'b0;
    initial begin
      wait (half_ns[g] != 0);
      forever begin
        #(half_ns[g] * 1ns);
        r = ~r;
      end
    end
    assign ro_out[g] = r;
  end

  always @(negedge clk) begin
    if (resp_valid && err) begin
      n_chk++;
      n_fail++;
      $display("FAIL rv_err_overlap: resp_valid and err both high at %0t", $time);
    end
  end

  function automatic int lo_c(input int idx);
    return WIN_NS / (2 * half_ns[idx]);
  endfunction
  function automatic int hi_c(input int idx);
    return (WIN_NS + 2 * half_ns[idx] - 1) / (2 * half_ns[idx]);
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic meas(input int a, input int b, output int lat);
    logic [15:0] exp_en;
    int en_cyc, bad;
    exp_en = (16'd1 << a) | (16'd1 << b);
    en_cyc = 0;
    bad = 0;
    @(negedge clk);
    chal_a = 4'(a); chal_b = 4'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 3000) begin
      if (ro_en == exp_en) en_cyc++;
      else if (ro_en != 16'd0) bad++;
      if (!busy) bad++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LAT);
    check("ro_en_cycles", en_cyc, 8 + 1024);
    check("ro_en_busy_bad", bad, 0);
    check("rv_busy", busy, 0);
    check("rv_ro_en", ro_en, 0);
  endtask

  task automatic run_legal(input int a, input int b, input bit exp_resp, input bit exp_tie);
    int lat;
    meas(a, b, lat);
    check_rng("cnt_a", cnt_a, lo_c(a), hi_c(a));
    check_rng("cnt_b", cnt_b, lo_c(b), hi_c(b));
    check("resp", resp, exp_resp);
    check("tie", tie, exp_tie);
    check("sat", sat, 0);
    @(negedge clk);
    check("rv_pulse", resp_valid, 0);
    check("resp_hold", resp, exp_resp);
  endtask

  initial begin
    int lat, bad;
    for (int i = 0; i < N; i++) half_ns[i] = 10 * $urandom_range(3, 40);
    half_ns[3] = 100;
    half_ns[5] = 100;
    half_ns[7] = 150;
    tbl[0] = '{a: 3, b: 7, exp_err: 1'b0, exp_resp: 1'b1, exp_tie: 1'b0};
    tbl[1] = '{a: 7, b: 3, exp_err: 1'b0, exp_resp: 1'b0, exp_tie: 1'b0};
    tbl[2] = '{a: 5, b: 5, exp_err: 1'b1, exp_resp: 1'b0, exp_tie: 1'b0};
    tbl[3] = '{a: 3, b: 5, exp_err: 1'b0, exp_resp: 1'b0, exp_tie: 1'b1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ro_en", ro_en, 0);
    check("rst_rv", resp_valid, 0);
    check("rst_err", err, 0);
    check("rst_resp", resp, 0);
    check("rst_cnt_a", cnt_a, 0);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].exp_err) begin
        @(negedge clk);
        chal_a = 4'(tbl[i].a); chal_b = 4'(tbl[i].b); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_ro_en", ro_en, 0);
        @(negedge clk);
        check("err_one_cycle", err, 0);
        bad = 0;
        repeat (20) begin
          if (resp_valid || busy || ro_en != 16'd0) bad++;
          @(negedge clk);
        end
        check("err_no_activity", bad, 0);
      end else begin
        run_legal(tbl[i].a, tbl[i].b, tbl[i].exp_resp, tbl[i].exp_tie);
        check("sat4_cnt_a", s_cnt_a, 15);
        check("sat4_cnt_b", s_cnt_b, 15);
        check("sat4_sat", s_sat, 1);
        check("sat4_tie", s_tie, 1);
        check("sat4_resp", s_resp, 0);
      end
    end

    // Busy re-pulse is ignored, then start held high gives back-to-back runs
    @(negedge clk);
    chal_a = 4'd3; chal_b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 3000) begin
      if (lat == 600) begin start = 1'b1; chal_a = 4'd7; chal_b = 4'd3; end
      if (lat == 601) start = 1'b0;
      if (lat == 900) start = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("b2b_first_lat", lat, LAT);
    check("b2b_first_resp", resp, 1);
    lat = 0;
    @(negedge clk);
    lat++;
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_en", ro_en, 16'h0088);
    while (!resp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("b2b_spacing", lat, LAT);
    check("b2b_second_resp", resp, 0);
    @(negedge clk);

    // Reset 500 cycles into MEASURE
    @(negedge clk);
    chal_a = 4'd3; chal_b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8 + 500 - 1) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2ns rst = 1'b1;
    #1ns;
    check("rst_async_ro_en", ro_en, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_resp", resp, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (1100) begin
      if (resp_valid || err || busy) bad++;
      @(negedge clk);
    end
    check("rst_no_rv", bad, 0);
    run_legal(3, 7, 1'b1, 1'b0);

    // Random challenges with clearly separated expected counts
    for (int r = 0; r < 4; r++) begin
      int a, b, tries;
      tries = 0;
      do begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        tries++;
      end while ((a == b || !(hi_c(a) < lo_c(b) || hi_c(b) < lo_c(a))) && tries < 500);
      if (a == b || !(hi_c(a) < lo_c(b) || hi_c(b) < lo_c(a))) begin
        a = 3;
        b = 7;
      end
      run_legal(a, b, lo_c(a) > hi_c(b), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
